// File: rtl/uart_pkg.sv
// Shared register map, CTRL/STATUS bit positions and FSM encodings for the UART.
package uart_pkg;

  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_RXDATA = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  // CTRL bit positions inside the 7-bit control register (bus bits [14:8])
  localparam int unsigned CTRL_PARITY_EN  = 0;
  localparam int unsigned CTRL_PARITY_ODD = 1;
  localparam int unsigned CTRL_TWO_STOP   = 2;
  localparam int unsigned CTRL_LOOPBACK   = 3;
  localparam int unsigned CTRL_RX_IE      = 4;
  localparam int unsigned CTRL_TX_IE      = 5;
  localparam int unsigned CTRL_ERR_IE     = 6;
  localparam int unsigned CTRL_W          = 7;

  // STATUS bit positions (bus bits [7:0])
  localparam int unsigned STAT_TX_FULL    = 0;
  localparam int unsigned STAT_TX_EMPTY   = 1;
  localparam int unsigned STAT_RX_EMPTY   = 2;
  localparam int unsigned STAT_RX_FULL    = 3;
  localparam int unsigned STAT_OVERRUN    = 4;
  localparam int unsigned STAT_FRAME_ERR  = 5;
  localparam int unsigned STAT_PARITY_ERR = 6;
  localparam int unsigned STAT_TX_BUSY    = 7;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; overflowing pushes and underflowing pops are ignored.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign data_out = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/uart_core.sv
// UART with TX/RX FIFOs, selectable parity/stop bits, loopback and a Wishbone-style register port.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned DIV_RESET  = 6,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        tx_bit,
  input  logic        rx_bit,
  input  logic [1:0]  wb_addr,
  input  logic [15:0] wb_data_in,
  output logic [15:0] wb_data_out,
  input  logic        wb_we,
  input  logic        wb_stb,
  output logic        wb_ack,
  output logic        irq
);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS);
  localparam int unsigned RXW = DATA_BITS + 2;

  // Bus access latched at request, executed during the ack cycle
  logic [1:0]  acc_addr;
  logic        acc_we;
  logic [15:0] acc_data;
  logic        acc_pop_ok;
  logic [15:0] rd_mux;
  logic        tx_push, rx_pop, div_wr, ctrl_wr;

  logic [DIV_WIDTH-1:0] div_reg, div_act, tick_cnt;
  logic                 tick;
  logic [CTRL_W-1:0]    ctrl;
  logic                 overrun, frame_err, parity_err;
  logic [7:0]           status;

  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_full, tx_empty, tx_pop, tx_frame_done, tx_busy;
  logic [CW-1:0]        tx_count;
  tx_state_e            tx_state;
  logic [OW-1:0]        tx_os;
  logic [BW-1:0]        tx_idx;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par, tx_pen, tx_two, tx_stop2;

  logic [RXW-1:0]       rx_head, rx_entry;
  logic                 rx_full, rx_empty, rx_push;
  logic [CW-1:0]        rx_count;
  rx_state_e            rx_state;
  logic [1:0]           rx_sync;
  logic                 rx_line, rx_prev;
  logic [OW-1:0]        rx_os;
  logic [BW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_perr, rx_pen, rx_podd;

  assign tx_push = wb_ack && acc_we && (acc_addr == ADDR_TXDATA);
  assign rx_pop  = wb_ack && acc_pop_ok;
  assign div_wr  = wb_ack && acc_we && (acc_addr == ADDR_DIV);
  assign ctrl_wr = wb_ack && acc_we && (acc_addr == ADDR_CTRL);
  assign tx_busy = (tx_state != TX_IDLE);
  assign rx_line = ctrl[CTRL_LOOPBACK] ? tx_bit : rx_sync[1];
  assign tick    = (tick_cnt >= div_act);

  assign status = {tx_busy, parity_err, frame_err, overrun,
                   rx_full, rx_empty, (tx_count == '0), tx_full};

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop),
    .data_in(acc_data[DATA_BITS-1:0]), .data_out(tx_head),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart_fifo #(.WIDTH(RXW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop),
    .data_in(rx_entry), .data_out(rx_head),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // Read data selection for the access being acknowledged
  always_comb begin
    rd_mux = '0;
    case (wb_addr)
      ADDR_RXDATA: if (!rx_empty)
        rd_mux = {rx_head[DATA_BITS+1], rx_head[DATA_BITS], (14-DATA_BITS)'(0),
                  rx_head[DATA_BITS-1:0]};
      ADDR_DIV:    rd_mux = 16'(div_reg);
      ADDR_CTRL:   rd_mux = {1'b0, ctrl, status};
      default:     rd_mux = '0;
    endcase
  end

  // Bus handshake: one-cycle ack, registered read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_ack      <= 1'b0;
      wb_data_out <= '0;
      acc_addr    <= '0;
      acc_we      <= 1'b0;
      acc_data    <= '0;
      acc_pop_ok  <= 1'b0;
    end else begin
      wb_ack      <= wb_stb && !wb_ack;
      wb_data_out <= '0;
      acc_pop_ok  <= 1'b0;
      if (wb_stb && !wb_ack) begin
        acc_addr    <= wb_addr;
        acc_we      <= wb_we;
        acc_data    <= wb_data_in;
        acc_pop_ok  <= !wb_we && (wb_addr == ADDR_RXDATA) && !rx_empty;
        wb_data_out <= wb_we ? 16'h0000 : rd_mux;
      end
    end
  end

  // Baud tick generator; new divider only applied while both directions are idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      div_act  <= DIV_WIDTH'(DIV_RESET);
    end else begin
      if (div_wr || tick) tick_cnt <= '0;
      else                tick_cnt <= tick_cnt + 1'b1;
      if (!tx_busy && rx_state == RX_IDLE) div_act <= div_reg;
    end
  end

  // Control/divider registers, sticky error flags and interrupt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_reg    <= DIV_WIDTH'(DIV_RESET);
      ctrl       <= '0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (div_wr)  div_reg <= DIV_WIDTH'(acc_data);
      if (ctrl_wr) ctrl    <= acc_data[14:8];
      overrun    <= (overrun    && !(ctrl_wr && acc_data[STAT_OVERRUN]))
                 || (rx_push && (rx_count == CW'(FIFO_DEPTH)));
      frame_err  <= (frame_err  && !(ctrl_wr && acc_data[STAT_FRAME_ERR]))
                 || (rx_push && rx_entry[DATA_BITS+1]);
      parity_err <= (parity_err && !(ctrl_wr && acc_data[STAT_PARITY_ERR]))
                 || (rx_push && rx_entry[DATA_BITS]);
      irq <= (ctrl[CTRL_RX_IE] && !rx_empty)
          || (ctrl[CTRL_TX_IE] && tx_empty && !tx_busy)
          || (ctrl[CTRL_ERR_IE] && (overrun || frame_err || parity_err));
    end
  end

  assign tx_frame_done = tick && (tx_os == OW'(OVERSAMPLE-1)) && (tx_state == TX_STOP)
                         && (!tx_two || tx_stop2);
  assign tx_pop        = tick && !tx_empty && ((tx_state == TX_IDLE) || tx_frame_done);

  // Transmit FSM; frame settings captured when a byte is popped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_bit   <= 1'b1;
      tx_os    <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_pen   <= 1'b0;
      tx_two   <= 1'b0;
      tx_stop2 <= 1'b0;
    end else if (tx_pop) begin
      tx_state <= TX_START;
      tx_bit   <= 1'b0;
      tx_os    <= '0;
      tx_sh    <= tx_head;
      tx_par   <= (^tx_head) ^ ctrl[CTRL_PARITY_ODD];
      tx_pen   <= ctrl[CTRL_PARITY_EN];
      tx_two   <= ctrl[CTRL_TWO_STOP];
      tx_stop2 <= 1'b0;
    end else if (tx_busy && tick) begin
      if (tx_os != OW'(OVERSAMPLE-1)) begin
        tx_os <= tx_os + 1'b1;
      end else begin
        tx_os <= '0;
        case (tx_state)
          TX_START: begin
            tx_state <= TX_DATA;
            tx_idx   <= '0;
            tx_bit   <= tx_sh[0];
            tx_sh    <= tx_sh >> 1;
          end
          TX_DATA: begin
            if (tx_idx == BW'(DATA_BITS-1)) begin
              tx_state <= tx_pen ? TX_PARITY : TX_STOP;
              tx_bit   <= tx_pen ? tx_par : 1'b1;
            end else begin
              tx_idx <= tx_idx + 1'b1;
              tx_bit <= tx_sh[0];
              tx_sh  <= tx_sh >> 1;
            end
          end
          TX_PARITY: begin
            tx_state <= TX_STOP;
            tx_bit   <= 1'b1;
          end
          TX_STOP: begin
            if (tx_two && !tx_stop2) tx_stop2 <= 1'b1;
            else                     tx_state <= TX_IDLE;
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  // Receive FSM: synchronised line, mid-start validation, centre sampling
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_os    <= '0;
      rx_idx   <= '0;
      rx_sh    <= '0;
      rx_perr  <= 1'b0;
      rx_pen   <= 1'b0;
      rx_podd  <= 1'b0;
      rx_push  <= 1'b0;
      rx_entry <= '0;
    end else begin
      rx_sync <= {rx_sync[0], rx_bit};
      rx_prev <= rx_line;
      rx_push <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_line) begin
            rx_state <= RX_START;
            rx_os    <= '0;
            rx_perr  <= 1'b0;
            rx_pen   <= ctrl[CTRL_PARITY_EN];
            rx_podd  <= ctrl[CTRL_PARITY_ODD];
          end
        end
        RX_WAIT_HIGH: if (rx_line) rx_state <= RX_IDLE;
        RX_START: begin
          if (tick) begin
            if (rx_os == OW'(OVERSAMPLE/2-1)) begin
              rx_os    <= '0;
              rx_idx   <= '0;
              rx_state <= rx_line ? RX_IDLE : RX_DATA;
            end else begin
              rx_os <= rx_os + 1'b1;
            end
          end
        end
        default: begin
          if (tick) begin
            if (rx_os != OW'(OVERSAMPLE-1)) begin
              rx_os <= rx_os + 1'b1;
            end else begin
              rx_os <= '0;
              case (rx_state)
                RX_DATA: begin
                  rx_sh <= {rx_line, rx_sh[DATA_BITS-1:1]};
                  if (rx_idx == BW'(DATA_BITS-1)) rx_state <= rx_pen ? RX_PARITY : RX_STOP;
                  else                            rx_idx   <= rx_idx + 1'b1;
                end
                RX_PARITY: begin
                  rx_perr  <= rx_line ^ (^rx_sh) ^ rx_podd;
                  rx_state <= RX_STOP;
                end
                RX_STOP: begin
                  rx_push  <= 1'b1;
                  rx_entry <= {!rx_line, rx_perr, rx_sh};
                  rx_state <= rx_line ? RX_IDLE : RX_WAIT_HIGH;
                end
                default: rx_state <= RX_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
